// File: rtl/crack_seq.sv
// Launch/collect sequencer for a 24-bit key cracker with a six-digit seven-segment result display.
// Optional watchdog/abort path is built only when CRACK_TIMEOUT_EN is defined.
module crack_seq #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        crk_en,
    input  logic        crk_rdy,
    input  logic [23:0] crk_key,
    input  logic        crk_key_valid,
    output logic        crk_rst_n,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int unsigned KEY_W   = 24;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 6;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
`ifdef CRACK_TIMEOUT_EN
        ABORT     = 3'd5,
`endif
        SHOW      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               start_q;
    logic               armed_q;
    logic [KEY_W-1:0]   key_r_q, key_r_d;
    logic               valid_r_q, valid_r_d;
    logic               crk_en_q, crk_en_d;
    logic               crk_rst_n_q, crk_rst_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               start_edge;

`ifdef CRACK_TIMEOUT_EN
    localparam int unsigned WD_W = 32;
    logic [WD_W-1:0]    watchdog_q, watchdog_d;
    logic               abort_cnt_q, abort_cnt_d;
    logic               timeout_hit;
    assign timeout_hit = (watchdog_q == (TIMEOUT_CYCLES - 32'd1));
`else
    logic               unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // armed_q masks the first cycle after reset so a start already held high cannot look like an edge
    assign start_edge = start & ~start_q & armed_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
            key_r_q     <= '0;
            valid_r_q   <= 1'b0;
            crk_en_q    <= 1'b0;
            crk_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
`ifdef CRACK_TIMEOUT_EN
            watchdog_q  <= '0;
            abort_cnt_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            armed_q     <= 1'b1;
            key_r_q     <= key_r_d;
            valid_r_q   <= valid_r_d;
            crk_en_q    <= crk_en_d;
            crk_rst_n_q <= crk_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
`ifdef CRACK_TIMEOUT_EN
            watchdog_q  <= watchdog_d;
            abort_cnt_q <= abort_cnt_d;
`endif
        end
    end

    // Next-state and result capture
    always_comb begin
        state_d   = state_q;
        key_r_d   = key_r_q;
        valid_r_d = valid_r_q;
`ifdef CRACK_TIMEOUT_EN
        watchdog_d  = watchdog_q;
        abort_cnt_d = abort_cnt_q;
`endif
        case (state_q)
            IDLE, SHOW: begin
                if (start_edge && crk_rdy) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!crk_rdy) begin
                    state_d = WAIT_DONE;
                end
`ifdef CRACK_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = ABORT;
                    abort_cnt_d = 1'b0;
                end
`endif
            end
            WAIT_DONE: begin
                if (crk_rdy) begin
                    state_d   = SHOW;
                    key_r_d   = crk_key;
                    valid_r_d = crk_key_valid;
                end
`ifdef CRACK_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = ABORT;
                    abort_cnt_d = 1'b0;
                end
`endif
            end
`ifdef CRACK_TIMEOUT_EN
            ABORT: begin
                if (abort_cnt_q) begin
                    state_d   = SHOW;
                    valid_r_d = 1'b0;
                end else begin
                    abort_cnt_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef CRACK_TIMEOUT_EN
        if (state_d == LAUNCH) begin
            watchdog_d = '0;
        end else if (state_d == WAIT_BUSY || state_d == WAIT_DONE) begin
            watchdog_d = watchdog_q + 32'd1;
        end
`endif
    end

    // Output decode from the upcoming state so every flag is registered
    always_comb begin
        crk_en_d    = (state_d == LAUNCH);
        busy_d      = (state_d == LAUNCH) || (state_d == WAIT_BUSY) || (state_d == WAIT_DONE);
        done_d      = (state_d == SHOW);
        fail_d      = (state_d == SHOW) && !valid_r_d;
        crk_rst_n_d = 1'b1;
`ifdef CRACK_TIMEOUT_EN
        busy_d      = busy_d || (state_d == ABORT);
        crk_rst_n_d = (state_d != ABORT);
`endif
    end

    assign crk_en    = crk_en_q;
    assign crk_rst_n = crk_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;

    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    logic [SEG_W-1:0] digit [DIGITS];

    // Display decode: glyphs for a found key, dashes for no key, blank otherwise
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit[i] = SEG_BLANK;
            if (state_q == SHOW) begin
                digit[i] = valid_r_q ? hex_glyph(key_r_q[4*i +: 4]) : SEG_DASH;
            end
        end
    end

    assign hex0 = digit[0];
    assign hex1 = digit[1];
    assign hex2 = digit[2];
    assign hex3 = digit[3];
    assign hex4 = digit[4];
    assign hex5 = digit[5];

endmodule

// File: tb/tb_crack_seq.sv
// Scoreboard bench for crack_seq: a cracker model feeds results, expected displays are queued and
// checked when done rises. The watchdog scenario follows CRACK_TIMEOUT_EN.
module tb_crack_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        crk_en;
    logic        crk_rdy;
    logic [23:0] crk_key;
    logic        crk_key_valid;
    logic        crk_rst_n;
    logic        busy, done, fail;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef struct {
        logic [23:0] key;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   en_cnt = 0;
    int   en0;

    crack_seq #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .crk_en(crk_en),
        .crk_rdy(crk_rdy), .crk_key(crk_key), .crk_key_valid(crk_key_valid),
        .crk_rst_n(crk_rst_n), .busy(busy), .done(done), .fail(fail),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (crk_en) en_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    function automatic logic [6:0] hex_at(input int i);
        case (i)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            default: return hex5;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_en"}, 32'(crk_en), 32'd0);
        chk({tag, "_crst"}, 32'(crk_rst_n), 32'd1);
        chk({tag, "_hex0"}, 32'(hex0), 32'(BLANK));
        chk({tag, "_hex5"}, 32'(hex5), 32'(BLANK));
    endtask

    task automatic launch();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk("launch_en", 32'(crk_en), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_blank", 32'(hex0), 32'(BLANK));
    endtask

    task automatic cracker_busy();
        @(negedge clk) crk_rdy = 1'b0;
    endtask

    task automatic cracker_done(input logic [23:0] key, input logic valid);
        @(negedge clk);
        crk_key       = key;
        crk_key_valid = valid;
        crk_rdy       = 1'b1;
        sb.push_back('{key, valid});
    endtask

    task automatic wait_show();
        exp_t e;
        int   k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk("fail_flag", 32'(fail), 32'(!e.valid));
            chk("busy_off", 32'(busy), 32'd0);
            for (int i = 0; i < 6; i++)
                chk($sformatf("hex%0d", i), 32'(hex_at(i)),
                    32'(e.valid ? ref_glyph(e.key[4*i +: 4]) : DASH));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; crk_rdy = 1'b1; crk_key = '0; crk_key_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known key 1E4600 with fixed glyph expectations
        en0 = en_cnt;
        launch();
        start = 1'b0;
        @(negedge clk);
        chk("en_one_cycle", 32'(crk_en), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        cracker_busy();
        repeat (4) @(negedge clk);
        cracker_done(24'h1E4600, 1'b1);
        wait_show();
        chk("hex5_one", 32'(hex5), 32'h79);
        chk("hex4_e", 32'(hex4), 32'h06);
        chk("hex0_zero", 32'(hex0), 32'h40);
        chk("fail_clear", 32'(fail), 32'd0);
        chk("en_count1", 32'(en_cnt - en0), 32'd1);

        // No key found, relaunched from SHOW
        launch();
        start = 1'b0;
        cracker_busy();
        repeat (3) @(negedge clk);
        cracker_done(24'($urandom), 1'b0);
        wait_show();
        chk("dash_hex3", 32'(hex3), 32'(DASH));

        // Start toggles while cracker searches must not relaunch
        en0 = en_cnt;
        launch();
        start = 1'b0;
        cracker_busy();
        repeat (3) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        cracker_done(24'($urandom), 1'b1);
        wait_show();
        chk("en_no_extra", 32'(en_cnt - en0), 32'd1);

        // Random runs
        for (int r = 0; r < 3; r++) begin
            launch();
            start = 1'b0;
            cracker_busy();
            repeat ($urandom_range(1, 6)) @(negedge clk);
            cracker_done(24'($urandom), 1'($urandom_range(0, 1)));
            wait_show();
        end

        // Start edge in IDLE while cracker not ready is dropped
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        crk_rdy = 1'b0;
        en0 = en_cnt;
        @(negedge clk) start = 1'b1;
        repeat (4) @(negedge clk);
        chk("nordy_busy", 32'(busy), 32'd0);
        chk("nordy_en", 32'(en_cnt - en0), 32'd0);
        crk_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_pending", 32'(busy), 32'd0);
        start = 1'b0;

        // Asynchronous reset mid-search, start held across release
        launch();
        cracker_busy();
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_quiet("async_rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        crk_rdy = 1'b1;
        en0 = en_cnt;
        repeat (6) @(negedge clk);
        chk("held_start_busy", 32'(busy), 32'd0);
        chk("held_start_en", 32'(en_cnt - en0), 32'd0);
        start = 1'b0;
        @(negedge clk);

        // Watchdog behaviour with the cracker stuck busy
`ifdef CRACK_TIMEOUT_EN
        begin
            int cnt;
            launch();
            start = 1'b0;
            crk_rdy = 1'b0;
            cnt = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                cnt++;
                if (!crk_rst_n) break;
            end
            chk("abort_delay", 32'(cnt), 32'd100);
            chk("abort_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("abort_len2", 32'(crk_rst_n), 32'd0);
            sb.push_back('{24'h0, 1'b0});
            wait_show();
            chk("abort_rel", 32'(crk_rst_n), 32'd1);
            crk_rdy = 1'b1;
        end
`else
        launch();
        start = 1'b0;
        crk_rdy = 1'b0;
        repeat (150) @(negedge clk);
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_crst", 32'(crk_rst_n), 32'd1);
        chk("nowd_done", 32'(done), 32'd0);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        crk_rdy = 1'b1;
`endif
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crack_seq.md
CRACK_SEQ -- requirements
Module: crack_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd50_000_000, watchdog limit in clk cycles; used only when CRACK_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  level request, already synchronous to clk; only a 0->1 change is acted on.
REQ-005 crk_en  output  1  one-cycle launch pulse to the downstream cracker.
REQ-006 crk_rdy  input  1  cracker ready: 1 when idle or finished, 0 while searching.
REQ-007 crk_key  input  24  key reported by the cracker; meaningful when crk_rdy=1 after a run.
REQ-008 crk_key_valid  input  1  cracker found a key.
REQ-009 crk_rst_n  output  1  active-low abort reset to the cracker.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  result latched and displayed.
REQ-012 fail  output  1  run ended with no key, or aborted.
REQ-013 hex0..hex5  output  7 each  active-low seven-segment digits; hex5 is the most significant.

Function
REQ-014 States SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, SHOW and ABORT; reset state IDLE.
REQ-015 The start edge SHALL be detected with a registered copy of start: edge = start & ~start_q.
REQ-016 IDLE or SHOW, edge with crk_rdy=1 -> LAUNCH.
REQ-017 IDLE or SHOW, edge with crk_rdy=0 -> edge discarded; no pending request is kept.
REQ-018 In LAUNCH, crk_en=1 for exactly one cycle (the cycle after the edge sample); next state WAIT_BUSY; crk_en=0 in every other state.
REQ-019 WAIT_BUSY: crk_rdy=0 -> WAIT_DONE; otherwise remain.
REQ-020 WAIT_DONE: crk_rdy=1 -> SHOW, latching crk_key and crk_key_valid on that edge into key_r and valid_r.
REQ-021 busy=1 in LAUNCH, WAIT_BUSY, WAIT_DONE and ABORT; 0 otherwise.
REQ-022 done=1 only in SHOW; fail=1 in SHOW when valid_r=0; fail is cleared when leaving SHOW.
REQ-023 Start edges in LAUNCH, WAIT_BUSY, WAIT_DONE and ABORT SHALL be ignored.
REQ-024 Display in SHOW with valid_r=1: hex[i] shows the hex glyph 0-F of key_r[4i+3:4i].
REQ-025 Display in SHOW with valid_r=0: every digit shows dash, 7'b0111111.
REQ-026 Display in all other states: every digit blank, 7'b1111111.
REQ-027 Segment encoding (bit0 = seg a, ..., bit6 = seg g, active-low) SHALL be combinational from the registered key_r and state.
REQ-028 All outputs other than hex0..hex5 SHALL be registered.

Reset
REQ-029 Asserting rst_n low at any time, including mid-run, SHALL force on the next evaluation, without waiting for a clock: state=IDLE, crk_en=0, crk_rst_n=1, busy=0, done=0, fail=0, start_q=0, key_r=0, valid_r=0, watchdog=0, all digits blank.
REQ-030 After rst_n is released, a start already held high SHALL NOT launch a run; a 0->1 transition is required.

Configuration
REQ-031 Macro CRACK_TIMEOUT_EN defined: a 32-bit watchdog clears on entering LAUNCH and increments in WAIT_BUSY and WAIT_DONE.
REQ-032 With CRACK_TIMEOUT_EN, when the watchdog reaches TIMEOUT_CYCLES-1 before crk_rdy returns: -> ABORT, crk_rst_n=0 for exactly 2 cycles, then -> SHOW with valid_r=0 (fail=1, dashes displayed).
REQ-033 With CRACK_TIMEOUT_EN, if crk_rdy=1 and the timeout occur on the same edge, crk_rdy SHALL win (normal SHOW).
REQ-034 CRACK_TIMEOUT_EN undefined: no watchdog and no ABORT state; crk_rst_n is constant 1; WAIT_DONE waits indefinitely.

Verification
REQ-035 Reset, crk_rdy=1, start 0->1 -> crk_en high exactly 1 cycle, one cycle after the edge sample; busy=1.
REQ-036 Run with the cracker returning crk_key=24'h1E4600, crk_key_valid=1 -> done=1, fail=0; hex5..hex0 show 1,E,4,6,0,0 (hex5=7'b1111001, hex0=7'b1000000).
REQ-037 Run ending with crk_key_valid=0 -> fail=1; all digits 7'b0111111; a new start edge relaunches and blanks the display.
REQ-038 Start toggled 3 times during WAIT_DONE -> no extra crk_en pulse; a start edge with crk_rdy=0 in IDLE -> no launch.
REQ-039 rst_n pulsed low mid-WAIT_DONE, asynchronously between edges -> outputs reset immediately; start held high across release -> no launch.
REQ-040 CRACK_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, crk_rdy held 0 -> crk_rst_n low 2 cycles starting 100 cycles after LAUNCH, then fail=1; undefined build -> busy stays 1.
